// File: rtl/opcode_map_pkg.sv
// Shared opcode names and the default microprogram entry points.
// default_maddr() returns {valid, maddr} and is used to reload the table after reset.
package opcode_map_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int N_OPC       = 29;
    localparam int DEF_MADDR_W = 8;

    localparam int SETN  = 0;
    localparam int SETM  = 1;
    localparam int SETK  = 2;
    localparam int LDA   = 3;
    localparam int LDB   = 4;
    localparam int LDC   = 5;
    localparam int STC   = 6;
    localparam int CLRC  = 7;
    localparam int MACC  = 8;
    localparam int MACR  = 9;
    localparam int ADDM  = 10;
    localparam int SUBM  = 11;
    localparam int MULM  = 12;
    localparam int TRSP  = 13;
    localparam int SHLM  = 14;
    localparam int SHRM  = 15;
    localparam int RELU  = 16;
    localparam int BRZ   = 17;
    localparam int BRNZ  = 18;
    localparam int JMP   = 19;
    localparam int CALL  = 20;
    localparam int RET   = 21;
    localparam int NOP   = 22;
    localparam int HALT  = 23;
    localparam int SYNC  = 24;
    localparam int WAITI = 25;
    localparam int LDTR0 = 26;
    localparam int LDTR1 = 27;
    localparam int LDTR2 = 28;

    function automatic logic [DEF_MADDR_W:0] default_maddr(input int unsigned opc);
        logic [DEF_MADDR_W-1:0] m;
        m = '0;
        case (opc)
            SETN:  m = 8'd3;
            SETM:  m = 8'd7;
            SETK:  m = 8'd11;
            LDA:   m = 8'd15;
            LDB:   m = 8'd20;
            LDC:   m = 8'd28;
            STC:   m = 8'd37;
            CLRC:  m = 8'd41;
            MACC:  m = 8'd45;
            MACR:  m = 8'd48;
            ADDM:  m = 8'd51;
            SUBM:  m = 8'd54;
            MULM:  m = 8'd56;
            TRSP:  m = 8'd58;
            SHLM:  m = 8'd59;
            SHRM:  m = 8'd60;
            RELU:  m = 8'd61;
            BRZ:   m = 8'd72;
            BRNZ:  m = 8'd73;
            JMP:   m = 8'd74;
            CALL:  m = 8'd63;
            RET:   m = 8'd66;
            NOP:   m = 8'd67;
            HALT:  m = 8'd69;
            SYNC:  m = 8'd70;
            WAITI: m = 8'd71;
            LDTR0: m = 8'd62;
            LDTR1: m = 8'd57;
            LDTR2: m = 8'd55;
            default: m = '0;
        endcase
        return {(opc < N_OPC), m};
    endfunction

endpackage

// File: rtl/opcode_map_ram.sv
// Register-array table: one synchronous write port, one combinational read port.
// Latency: write lands at the clock edge; read is same-cycle (old data during a colliding write).
// Backpressure: none, always accepts a write.
module opcode_map_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = 5,
    parameter int W     = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdat,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdat
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/opcode_map_table.sv
// Programmable opcode -> microcode address map with a default reload after reset.
// Latency: 1 cycle from accept to map_valid; one lookup per cycle at full throughput.
// Backpressure: ir_ready drops while a result is held with map_ready low.
module opcode_map_table
    import opcode_map_pkg::*;
#(
    parameter int                 IR_W         = 16,
    parameter int                 OPC_W        = 5,
    parameter int                 MADDR_W      = 8,
    parameter logic [MADDR_W-1:0] ILLEGAL_ADDR = '0,
    parameter int                 CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IR_W-1:0]    ir_in,
    input  logic               ir_valid,
    output logic               ir_ready,
    output logic [MADDR_W-1:0] map_addr,
    output logic               map_illegal,
    output logic               map_valid,
    input  logic               map_ready,
    input  logic               cfg_we,
    input  logic [OPC_W-1:0]   cfg_opc,
    input  logic [MADDR_W-1:0] cfg_maddr,
    input  logic               cfg_en,
    output logic               cfg_ack,
    output logic               init_done,
    output logic [CNT_W-1:0]   illegal_cnt
);

    localparam int DEPTH = 2**OPC_W;
    localparam int W     = 1 + MADDR_W;

    state_t               r_state, w_state_nxt;
    logic [OPC_W-1:0]     r_idx;
    logic                 r_map_valid, r_map_illegal, r_cfg_ack;
    logic [MADDR_W-1:0]   r_map_addr;
    logic [CNT_W-1:0]     r_illegal_cnt;
    logic                 w_run, w_ir_ready, w_accept, w_illegal;
    logic                 w_we;
    logic [OPC_W-1:0]     w_waddr;
    logic [W-1:0]         w_wdat, w_rdat;
    logic [DEF_MADDR_W:0] w_def;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && (&r_idx)) begin
            w_state_nxt = ST_RUN;
        end
    end

    // rst gates the handshake so a lookup or write in a reset cycle is never taken
    always_comb begin
        w_run      = (r_state == ST_RUN) && !rst;
        w_ir_ready = w_run && (!r_map_valid || map_ready);
    end

    assign w_def    = default_maddr(32'(r_idx));
    assign w_accept = ir_valid && w_ir_ready;

    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdat  = '0;
        if (r_state == ST_INIT && !rst) begin
            w_we    = 1'b1;
            w_waddr = r_idx;
            w_wdat  = {w_def[DEF_MADDR_W], MADDR_W'(w_def[DEF_MADDR_W-1:0])};
        end else if (w_run && cfg_we) begin
            w_we    = 1'b1;
            w_waddr = cfg_opc;
            w_wdat  = {cfg_en, cfg_maddr};
        end
    end

    opcode_map_ram #(
        .DEPTH (DEPTH),
        .AW    (OPC_W),
        .W     (W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdat  (w_wdat),
        .i_raddr (ir_in[OPC_W-1:0]),
        .o_rdat  (w_rdat)
    );

    assign w_illegal = (|ir_in[IR_W-1:OPC_W]) || !w_rdat[MADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_map_valid   <= 1'b0;
            r_map_addr    <= '0;
            r_map_illegal <= 1'b0;
            r_cfg_ack     <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_cfg_ack <= w_run && cfg_we;
            if (w_accept) begin
                r_map_valid   <= 1'b1;
                r_map_addr    <= w_illegal ? ILLEGAL_ADDR : w_rdat[MADDR_W-1:0];
                r_map_illegal <= w_illegal;
            end else if (map_ready) begin
                r_map_valid <= 1'b0;
            end
            if (r_map_valid && map_ready && r_map_illegal && !(&r_illegal_cnt)) begin
                r_illegal_cnt <= r_illegal_cnt + 1'b1;
            end
        end
    end

    assign ir_ready    = w_ir_ready;
    assign map_valid   = r_map_valid;
    assign map_addr    = r_map_addr;
    assign map_illegal = r_map_illegal;
    assign cfg_ack     = r_cfg_ack;
    assign init_done   = (r_state == ST_RUN);
    assign illegal_cnt = r_illegal_cnt;

endmodule
